// File: rtl/hc595_shift_store_if.sv
// Bus bundle for the hc595_shift_store serial-to-parallel register.
// The master side drives the serial stream and strobes; the slave side
// (the register itself) returns the parallel word, cascade bit and frame pulse.
interface hc595_shift_store_if #(
   parameter int WIDTH = 8
);
   logic             ser;
   logic             sh_en;
   logic             st_en;
   logic             clr;
   logic             oe_n;
   logic [WIDTH-1:0] q;
   logic             q_oe;
   logic             qs;
   logic             done;

   modport master (
      output ser, sh_en, st_en, clr, oe_n,
      input  q, q_oe, qs, done
   );

   modport slave (
      input  ser, sh_en, st_en, clr, oe_n,
      output q, q_oe, qs, done
   );
endinterface

// File: rtl/hc595_shift_store.sv
// 74HC595-style serial-in / parallel-out shift register with a storage register.
// Shift and store are clock enables on a single clock. With AUTO_LATCH set, a
// completed frame of WIDTH shifts is copied to storage one cycle later and
// flagged with a one-cycle done pulse.
module hc595_shift_store #(
   parameter int WIDTH      = 8,
   parameter bit AUTO_LATCH = 1'b1
) (
   input logic                clk,
   input logic                rst,
   hc595_shift_store_if.slave bus
);

   localparam int             CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  CNT_MAX  = CW'(WIDTH - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

   typedef enum logic {
      FILL  = 1'b0,
      LATCH = 1'b1
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] stor;
   logic [CW-1:0]    cnt;
   logic             last_bit;
   logic             done;

   assign last_bit = (cnt == CNT_MAX);

   // Frame state register; reset aborts any frame or pending latch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FILL;
      end else begin
         state <= next_state;
      end
   end

   // A shift that completes a frame moves to LATCH for exactly one cycle; a clear wins over the shift.
   always_comb begin
      next_state = state;
      done       = 1'b0;
      case (state)
         FILL: begin
            if (!bus.clr && bus.sh_en && last_bit && AUTO_LATCH) begin
               next_state = LATCH;
            end
         end
         LATCH: begin
            done       = 1'b1;
            next_state = FILL;
         end
         default: begin
            next_state = FILL;
         end
      endcase
   end

   // Shift register and bit counter: clear beats shift, the counter wraps at the end of a frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr  <= '0;
         cnt <= '0;
      end else if (bus.clr) begin
         sr  <= '0;
         cnt <= '0;
      end else if (bus.sh_en) begin
         sr  <= {sr[WIDTH-2:0], bus.ser};
         cnt <= last_bit ? '0 : cnt + CNT_ONE;
      end
   end

   // Storage takes the pre-edge shift register on an explicit store or on the auto-latch cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stor <= '0;
      end else if (bus.st_en || (state == LATCH)) begin
         stor <= sr;
      end
   end

   assign bus.q    = bus.oe_n ? '0 : stor;
   assign bus.q_oe = ~bus.oe_n;
   assign bus.qs   = sr[WIDTH-1];
   assign bus.done = done;

endmodule

// File: tb/tb_hc595_shift_store.sv
// Self-checking bench for hc595_shift_store: an auto-latch instance fed through
// a frame scoreboard, plus a manual-store instance.
module tb_hc595_shift_store;

   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks     = 0;
   int errors     = 0;
   int cycle      = 0;
   int done2_count = 0;

   logic [WIDTH-1:0] exp_q[$];
   int               done_cycles[$];
   logic [WIDTH-1:0] frame_exp;
   logic [WIDTH-1:0] model_sr;
   logic [WIDTH-1:0] pattern;
   int               n0;

   hc595_shift_store_if #(.WIDTH(WIDTH)) bus ();
   hc595_shift_store_if #(.WIDTH(WIDTH)) bus2 ();

   hc595_shift_store #(.WIDTH(WIDTH), .AUTO_LATCH(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   hc595_shift_store #(.WIDTH(WIDTH), .AUTO_LATCH(1'b0)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle counter used to measure spacing between frame pulses
   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic ser, input logic sh, input logic st, input logic cl);
      bus.ser   = ser;
      bus.sh_en = sh;
      bus.st_en = st;
      bus.clr   = cl;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus2(input logic ser, input logic sh, input logic st, input logic cl);
      bus2.ser   = ser;
      bus2.sh_en = sh;
      bus2.st_en = st;
      bus2.clr   = cl;
      @(posedge clk);
      #1;
   endtask

   task automatic shiftByte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) applyStimulus(b[i], 1'b1, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Scoreboard: each frame pulse pops the expected word and checks Q one cycle later
   always @(negedge clk) begin
      if (!rst && bus.done === 1'b1) begin
         done_cycles.push_back(cycle);
         if (exp_q.size() == 0) begin
            checkOutput("spurious_done", 32'(bus.done), 32'd0);
         end else begin
            frame_exp = exp_q.pop_front();
            @(negedge clk);
            checkOutput("q_frame", 32'(bus.q), 32'(frame_exp));
         end
      end
   end

   // Manual-store instance must never pulse done
   always @(negedge clk) begin
      if (!rst && bus2.done === 1'b1) done2_count++;
   end

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL timeout: got running, expected finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      bus.ser = 1'b0;  bus.sh_en = 1'b0;  bus.st_en = 1'b0;  bus.clr = 1'b0;  bus.oe_n = 1'b0;
      bus2.ser = 1'b0; bus2.sh_en = 1'b0; bus2.st_en = 1'b0; bus2.clr = 1'b0; bus2.oe_n = 1'b0;

      // Reset held with serial ones and toggling shift strobe
      for (int i = 0; i < 6; i++) begin
         bus.ser    = 1'b1;
         bus.sh_en  = i[0];
         bus2.ser   = 1'b1;
         bus2.sh_en = i[0];
         bus.oe_n   = (i == 3);
         @(posedge clk);
         #1;
         checkOutput("rst_q", 32'(bus.q), 32'd0);
         checkOutput("rst_qs", 32'(bus.qs), 32'd0);
         checkOutput("rst_done", 32'(bus.done), 32'd0);
         checkOutput("rst_q_oe", 32'(bus.q_oe), (i == 3) ? 32'd0 : 32'd1);
         checkOutput("rst_q2", 32'(bus2.q), 32'd0);
      end
      bus.oe_n   = 1'b0;
      bus.sh_en  = 1'b0;
      bus2.sh_en = 1'b0;
      bus2.ser   = 1'b0;
      rst        = 1'b0;
      idle(1);

      // Frame 0xA5 MSB first with auto-latch
      pattern  = 8'hA5;
      model_sr = '0;
      exp_q.push_back(pattern);
      for (int i = 7; i >= 0; i--) begin
         applyStimulus(pattern[i], 1'b1, 1'b0, 1'b0);
         model_sr = {model_sr[WIDTH-2:0], pattern[i]};
         checkOutput("t2_qs", 32'(bus.qs), 32'(model_sr[WIDTH-1]));
      end
      checkOutput("t2_done_high", 32'(bus.done), 32'd1);
      idle(1);
      checkOutput("t2_done_low", 32'(bus.done), 32'd0);
      checkOutput("t2_q", 32'(bus.q), 32'hA5);
      idle(1);

      // Store and shift in the same edge: storage sees the pre-shift word
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(8'hF2);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("t3_stor_preshift", 32'(bus.q), 32'h3C);
      checkOutput("t3_qs_0x79", 32'(bus.qs), 32'd0);
      checkOutput("t3_no_done", 32'(bus.done), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("t3_qs_0xf2", 32'(bus.qs), 32'd1);
      idle(2);

      // Partial frame discarded by clear, then a clean 0x81 frame
      n0 = done_cycles.size();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      exp_q.push_back(8'h81);
      shiftByte(8'h81);
      idle(3);
      checkOutput("t4_done_count", 32'(done_cycles.size() - n0), 32'd1);
      checkOutput("t4_q", 32'(bus.q), 32'h81);

      // Back-to-back frames 0x12, 0x34
      n0 = done_cycles.size();
      exp_q.push_back(8'h12);
      exp_q.push_back(8'h34);
      shiftByte(8'h12);
      shiftByte(8'h34);
      idle(3);
      checkOutput("t5_done_count", 32'(done_cycles.size() - n0), 32'd2);
      if (done_cycles.size() >= n0 + 2)
         checkOutput("t5_done_spacing", 32'(done_cycles[n0+1] - done_cycles[n0]), 32'd8);
      checkOutput("t5_q", 32'(bus.q), 32'h34);

      // Output enable gating keeps storage intact
      exp_q.push_back(8'hFF);
      shiftByte(8'hFF);
      idle(2);
      checkOutput("t6_q_loaded", 32'(bus.q), 32'hFF);
      bus.oe_n = 1'b1;
      #1;
      checkOutput("t6_q_gated", 32'(bus.q), 32'd0);
      checkOutput("t6_q_oe_off", 32'(bus.q_oe), 32'd0);
      idle(2);
      checkOutput("t6_q_still_gated", 32'(bus.q), 32'd0);
      bus.oe_n = 1'b0;
      #1;
      checkOutput("t6_q_restored", 32'(bus.q), 32'hFF);
      checkOutput("t6_q_oe_on", 32'(bus.q_oe), 32'd1);

      // Manual-store instance: no auto latch, explicit store copies sr
      pattern = 8'h5A;
      applyStimulus2(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 7; i >= 0; i--) applyStimulus2(pattern[i], 1'b1, 1'b0, 1'b0);
      applyStimulus2(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus2(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("t7_no_done", 32'(done2_count), 32'd0);
      checkOutput("t7_q_unchanged", 32'(bus2.q), 32'd0);
      checkOutput("t7_qs", 32'(bus2.qs), 32'd0);
      applyStimulus2(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("t7_q_stored", 32'(bus2.q), 32'h5A);
      pattern = 8'hC3;
      for (int i = 7; i >= 0; i--) applyStimulus2(pattern[i], 1'b1, 1'b0, 1'b0);
      applyStimulus2(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("t7_q_held", 32'(bus2.q), 32'h5A);
      applyStimulus2(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("t7_q_second", 32'(bus2.q), 32'hC3);
      applyStimulus2(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("t7_no_done_end", 32'(done2_count), 32'd0);

      checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
